next_line_predictor: RTL

Next-line predictor (NLP) table for the fetch unit. It answers a two-slot lookup for the current fetch PC (slot 0 at `pc`, slot 1 at `pc+4`) with registered `NLPInfo`: valid, taken, target and bimodal state. IF1/IF2 consume the answer. The block also accepts the `NLPUpdate` request that IF3 issues after predecode and BPD arbitration, which makes the NLP the responder end of that interface.

---
 rtl/next_line_predictor_pkg.sv | 27 ++
 rtl/nlp_bim_counter.sv | 22 ++
 rtl/next_line_predictor.sv | 114 +++++++++++
 3 files changed

// File: rtl/next_line_predictor_pkg.sv
// Shared types and constants for the next-line predictor.
//   NLPInfo       : per-slot prediction returned to IF1/IF2
//   NLPUpdateInfo : training request issued by IF3 after predecode/BPD
//   BIM_*         : 2-bit bimodal counter encodings (bit 1 = predict taken)
package next_line_predictor_pkg;

    localparam logic [1:0] BIM_STRONG_NT = 2'b00;
    localparam logic [1:0] BIM_WEAK_NT   = 2'b01;
    localparam logic [1:0] BIM_WEAK_T    = 2'b10;
    localparam logic [1:0] BIM_STRONG_T  = 2'b11;

    typedef struct packed {
        logic        valid;
        logic        taken;
        logic [31:0] target;
        logic [1:0]  bimState;
    } NLPInfo;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] target;
        logic [1:0]  bimState;
        logic        shouldTake;
    } NLPUpdateInfo;

endpackage

// File: rtl/nlp_bim_counter.sv
// Combinational 2-bit saturating counter step.
//   bim_in  : current counter value
//   taken   : resolved direction (1 = count up, 0 = count down)
//   bim_out : saturated next value
module nlp_bim_counter
    import next_line_predictor_pkg::*;
(
    input  logic [1:0] bim_in,
    input  logic       taken,
    output logic [1:0] bim_out
);

    always_comb begin
        bim_out = bim_in;
        if (taken) begin
            if (bim_in != BIM_STRONG_T) bim_out = bim_in + 2'd1;
        end else begin
            if (bim_in != BIM_STRONG_NT) bim_out = bim_in - 2'd1;
        end
    end

endmodule

// File: rtl/next_line_predictor.sv
// Next-line predictor table. Two-slot lookup (pc, pc+4) with registered
// NLPInfo answers, trained by IF3 update requests.
//   clk, rst             : clock, synchronous active-high reset
//   lookup_en, lookup_pc : capture a new lookup; outputs hold when lookup_en=0
//   nlp_info0/1          : registered prediction for lookup_pc / lookup_pc+4
//   update               : training write (allocate or overwrite)
module next_line_predictor
    import next_line_predictor_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         lookup_en,
    input  logic [31:0]  lookup_pc,
    output NLPInfo       nlp_info0,
    output NLPInfo       nlp_info1,
    input  NLPUpdateInfo update
);

    localparam int IDX_W = $clog2(ENTRIES);

    // Flop-array storage; only the valid bits are reset.
    logic [ENTRIES-1:0]            tbl_valid;
    logic [ENTRIES-1:0][TAG_W-1:0] tbl_tag;
    logic [ENTRIES-1:0][31:0]      tbl_target;
    logic [ENTRIES-1:0][1:0]       tbl_bim;

    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic [1:0]       upd_bim;
    NLPInfo           upd_info;

    assign upd_idx = update.pc[2 +: IDX_W];
    assign upd_tag = update.pc[2+IDX_W +: TAG_W];

    nlp_bim_counter u_bim (
        .bim_in  (update.bimState),
        .taken   (update.shouldTake),
        .bim_out (upd_bim)
    );

    // Post-update view of the written entry, used by the same-cycle bypass.
    always_comb begin
        upd_info          = '0;
        upd_info.valid    = 1'b1;
        upd_info.taken    = upd_bim[1];
        upd_info.target   = update.target;
        upd_info.bimState = upd_bim;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tbl_valid <= '0;
        end else if (update.valid) begin
            tbl_valid[upd_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && update.valid) begin
            tbl_tag[upd_idx]    <= upd_tag;
            tbl_target[upd_idx] <= update.target;
            tbl_bim[upd_idx]    <= upd_bim;
        end
    end

    // Slot PCs; slot 1 wraps modulo 2^32.
    logic [1:0][31:0] slot_pc;
    assign slot_pc[0] = lookup_pc;
    assign slot_pc[1] = lookup_pc + 32'd4;

    for (genvar s = 0; s < 2; s++) begin : g_slot
        logic [IDX_W-1:0] idx;
        logic [TAG_W-1:0] tag;
        NLPInfo           info;
        NLPInfo           info_q;

        assign idx = slot_pc[s][2 +: IDX_W];
        assign tag = slot_pc[s][2+IDX_W +: TAG_W];

        // Write-first: an update to this index overrides the stored entry,
        // so an index match with a tag mismatch is a miss even if the old
        // entry would have hit.
        always_comb begin
            info = '0;
            if (update.valid && upd_idx == idx) begin
                if (upd_tag == tag) info = upd_info;
            end else if (tbl_valid[idx] && tbl_tag[idx] == tag) begin
                info.valid    = 1'b1;
                info.taken    = tbl_bim[idx][1];
                info.target   = tbl_target[idx];
                info.bimState = tbl_bim[idx];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                info_q <= '0;
            end else if (lookup_en) begin
                info_q <= info;
            end
        end
    end

    assign nlp_info0 = g_slot[0].info_q;
    assign nlp_info1 = g_slot[1].info_q;

    // Offset bits and PC bits above the tag do not participate.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{slot_pc, update.pc};

endmodule
